// File: rtl/ddr_write_pkg.sv
// Shared definitions for the DDR frame writer: FSM encoding and default
// buffer geometry.
package ddr_write_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    REQ       = 3'd2,
    WAIT_DONE = 3'd3,
    FRAME_END = 3'd4
  } state_t;

  localparam logic [31:0] DEF_BUF0_BASE  = 32'h7000_0000;
  localparam logic [31:0] DEF_BUF1_BASE  = 32'h7080_0000;
  localparam int          DEF_BURST_LEN  = 256;
  localparam int          DEF_BEAT_BYTES = 8;

  // Byte distance between consecutive burst start addresses.
  localparam int          BURST_BYTES    = DEF_BURST_LEN * DEF_BEAT_BYTES;

endpackage

// File: rtl/ddr_write_edge_det.sv
// Rising-edge detector for the already-synchronized frame-start level.
// A level held high produces a single one-cycle pulse.
module ddr_write_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic level_d;

  // Remember the previous level so a rise can be spotted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_d <= 1'b0;
    else        level_d <= level;
  end

  assign pulse = level & ~level_d;

endmodule

// File: rtl/ddr_write_frame_ctrl.sv
// Sequences one video frame into DDR as fixed-size write bursts over a
// ping-pong pair of buffers, handshaking each burst with the DDR write
// master and publishing the last completed buffer to the read side.
module ddr_write_frame_ctrl
  import ddr_write_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BUF0_BASE  = ADDR_WIDTH'(DEF_BUF0_BASE),
  parameter logic [ADDR_WIDTH-1:0] BUF1_BASE  = ADDR_WIDTH'(DEF_BUF1_BASE),
  parameter int                    BURST_LEN  = DEF_BURST_LEN,
  parameter int                    BEAT_BYTES = DEF_BEAT_BYTES,
  parameter int                    H_BURSTS   = 4,
  parameter int                    V_LINES    = 1080
) (
  input  logic                  sys_clk,
  input  logic                  rstn_i,
  input  logic                  frame_start_sync_i,
  input  logic                  burst_rdy_i,
  input  logic                  wr_ack_i,
  input  logic                  wr_done_i,
  output logic                  wr_req_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [15:0]           wr_len_o,
  output logic                  wr_buf_sel_o,
  output logic                  rd_buf_sel_o,
  output logic                  frame_done_o,
  output logic                  frame_err_o,
  output logic                  busy_o
);

  localparam int HW = (H_BURSTS > 1) ? $clog2(H_BURSTS) : 1;
  localparam int VW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_BURSTS - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_LINES - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BURST_LEN * BEAT_BYTES);

  state_t                  state, state_next;
  logic [HW-1:0]           hcnt, hcnt_next;
  logic [VW-1:0]           vcnt, vcnt_next;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic                    req_next;
  logic                    wr_sel_next;
  logic                    rd_sel_next;
  logic                    restart_pend, pend_next;
  logic                    err_next;
  logic                    fs_pulse;

  ddr_write_edge_det u_edge_det (
    .clk   (sys_clk),
    .rst_n (rstn_i),
    .level (frame_start_sync_i),
    .pulse (fs_pulse)
  );

  function automatic logic [ADDR_WIDTH-1:0] base_of(input logic sel);
    return sel ? BUF1_BASE : BUF0_BASE;
  endfunction

  assign wr_len_o     = 16'(BURST_LEN);
  assign busy_o       = (state != IDLE);
  assign frame_done_o = (state == FRAME_END);

  // Register the FSM state together with the address, counters and flags.
  always_ff @(posedge sys_clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= IDLE;
      hcnt         <= '0;
      vcnt         <= '0;
      wr_addr_o    <= BUF0_BASE;
      wr_req_o     <= 1'b0;
      wr_buf_sel_o <= 1'b0;
      rd_buf_sel_o <= 1'b0;
      restart_pend <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      state        <= state_next;
      hcnt         <= hcnt_next;
      vcnt         <= vcnt_next;
      wr_addr_o    <= addr_next;
      wr_req_o     <= req_next;
      wr_buf_sel_o <= wr_sel_next;
      rd_buf_sel_o <= rd_sel_next;
      restart_pend <= pend_next;
      frame_err_o  <= err_next;
    end
  end

  // Next-state and datapath decisions; a mid-frame start is deferred until
  // no burst is in flight, then restarts the same buffer from its base.
  always_comb begin
    state_next  = state;
    hcnt_next   = hcnt;
    vcnt_next   = vcnt;
    addr_next   = wr_addr_o;
    req_next    = wr_req_o;
    wr_sel_next = wr_buf_sel_o;
    rd_sel_next = rd_buf_sel_o;
    err_next    = fs_pulse && (state != IDLE);
    pend_next   = restart_pend || (fs_pulse && (state != IDLE));

    case (state)
      IDLE: begin
        if (fs_pulse || restart_pend) begin
          state_next = WAIT_DATA;
          addr_next  = base_of(wr_buf_sel_o);
          hcnt_next  = '0;
          vcnt_next  = '0;
          pend_next  = 1'b0;
        end
      end
      WAIT_DATA: begin
        if (pend_next) begin
          addr_next = base_of(wr_buf_sel_o);
          hcnt_next = '0;
          vcnt_next = '0;
          pend_next = 1'b0;
        end
        if (burst_rdy_i) begin
          state_next = REQ;
          req_next   = 1'b1;
        end
      end
      REQ: begin
        if (wr_ack_i) begin
          state_next = WAIT_DONE;
          req_next   = 1'b0;
        end
      end
      WAIT_DONE: begin
        if (wr_done_i) begin
          if (pend_next) begin
            state_next = WAIT_DATA;
            addr_next  = base_of(wr_buf_sel_o);
            hcnt_next  = '0;
            vcnt_next  = '0;
            pend_next  = 1'b0;
          end else begin
            addr_next = wr_addr_o + STEP;
            if (hcnt == H_LAST) begin
              hcnt_next = '0;
              if (vcnt == V_LAST) begin
                state_next = FRAME_END;
              end else begin
                vcnt_next  = vcnt + 1'b1;
                state_next = WAIT_DATA;
              end
            end else begin
              hcnt_next  = hcnt + 1'b1;
              state_next = WAIT_DATA;
            end
          end
        end
      end
      FRAME_END: begin
        rd_sel_next = wr_buf_sel_o;
        wr_sel_next = ~wr_buf_sel_o;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ddr_write_frame_ctrl.sv
// Directed bench for ddr_write_frame_ctrl with a 2x2-burst frame.
module tb_ddr_write_frame_ctrl;

  logic        sys_clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        frame_start_sync_i = 1'b0;
  logic        burst_rdy_i = 1'b0;
  logic        wr_ack_i = 1'b0;
  logic        wr_done_i = 1'b0;
  logic        wr_req_o;
  logic [31:0] wr_addr_o;
  logic [15:0] wr_len_o;
  logic        wr_buf_sel_o;
  logic        rd_buf_sel_o;
  logic        frame_done_o;
  logic        frame_err_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;
  int done_pulses = 0;
  int err_pulses = 0;

  ddr_write_frame_ctrl #(
    .ADDR_WIDTH (32),
    .H_BURSTS   (2),
    .V_LINES    (2)
  ) dut (
    .sys_clk            (sys_clk),
    .rstn_i             (rstn_i),
    .frame_start_sync_i (frame_start_sync_i),
    .burst_rdy_i        (burst_rdy_i),
    .wr_ack_i           (wr_ack_i),
    .wr_done_i          (wr_done_i),
    .wr_req_o           (wr_req_o),
    .wr_addr_o          (wr_addr_o),
    .wr_len_o           (wr_len_o),
    .wr_buf_sel_o       (wr_buf_sel_o),
    .rd_buf_sel_o       (rd_buf_sel_o),
    .frame_done_o       (frame_done_o),
    .frame_err_o        (frame_err_o),
    .busy_o             (busy_o)
  );

  always #5 sys_clk = ~sys_clk;

  // Count one-cycle status pulses mid-cycle, away from the active edge.
  always @(negedge sys_clk) begin
    if (frame_done_o) done_pulses++;
    if (frame_err_o)  err_pulses++;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fs, input logic rdy,
                               input logic ack, input logic done);
    frame_start_sync_i = fs;
    burst_rdy_i        = rdy;
    wr_ack_i           = ack;
    wr_done_i          = done;
  endtask

  task automatic waitReq(output int n);
    n = 0;
    while (wr_req_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  // Serve one burst: ack and done each arrive three cycles after the prior step.
  task automatic serviceBurst(input string tag, input logic [31:0] exp_addr,
                              input bit fs_mid, input bit rdy_low_at_done);
    int n;
    waitReq(n);
    checkOutput({tag, " req_seen"}, 32'(wr_req_o), 32'd1);
    checkOutput({tag, " addr"}, wr_addr_o, exp_addr);
    if (fs_mid) begin
      frame_start_sync_i = 1'b1;
      tick();
      frame_start_sync_i = 1'b0;
      checkOutput({tag, " frame_err"}, 32'(frame_err_o), 32'd1);
      repeat (2) tick();
    end else begin
      repeat (3) tick();
    end
    checkOutput({tag, " req_hold"}, 32'(wr_req_o), 32'd1);
    checkOutput({tag, " addr_hold"}, wr_addr_o, exp_addr);
    wr_ack_i = 1'b1;
    tick();
    wr_ack_i = 1'b0;
    checkOutput({tag, " req_drop"}, 32'(wr_req_o), 32'd0);
    repeat (3) tick();
    wr_done_i = 1'b1;
    if (rdy_low_at_done) burst_rdy_i = 1'b0;
    tick();
    wr_done_i = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : stimulus
    int n;
    int req_seen;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    rstn_i = 1'b1;
    tick();
    checkOutput("reset req", 32'(wr_req_o), 32'd0);
    checkOutput("reset addr", wr_addr_o, 32'h7000_0000);
    checkOutput("reset len", 32'(wr_len_o), 32'd256);
    checkOutput("reset busy", 32'(busy_o), 32'd0);
    checkOutput("reset wr_sel", 32'(wr_buf_sel_o), 32'd0);
    checkOutput("reset rd_sel", 32'(rd_buf_sel_o), 32'd0);
    checkOutput("reset done", 32'(frame_done_o), 32'd0);
    checkOutput("reset err", 32'(frame_err_o), 32'd0);

    $display("[TB] frame 1 on buffer 0");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    waitReq(n);
    checkOutput("f1 latency", 32'(n), 32'd2);
    frame_start_sync_i = 1'b0;
    serviceBurst("f1 b0", 32'h7000_0000, 1'b0, 1'b0);
    serviceBurst("f1 b1", 32'h7000_0800, 1'b0, 1'b0);
    serviceBurst("f1 b2", 32'h7000_1000, 1'b0, 1'b0);
    serviceBurst("f1 b3", 32'h7000_1800, 1'b0, 1'b0);
    checkOutput("f1 frame_done", 32'(frame_done_o), 32'd1);
    tick();
    checkOutput("f1 done count", 32'(done_pulses), 32'd1);
    checkOutput("f1 rd_sel", 32'(rd_buf_sel_o), 32'd0);
    checkOutput("f1 wr_sel", 32'(wr_buf_sel_o), 32'd1);
    checkOutput("f1 idle", 32'(busy_o), 32'd0);

    $display("[TB] frame 2 on buffer 1 with start level held 10 cycles");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    waitReq(n);
    checkOutput("f2 latency", 32'(n), 32'd2);
    repeat (8) tick();
    frame_start_sync_i = 1'b0;
    serviceBurst("f2 b0", 32'h7080_0000, 1'b0, 1'b0);
    serviceBurst("f2 b1", 32'h7080_0800, 1'b0, 1'b0);
    serviceBurst("f2 b2", 32'h7080_1000, 1'b0, 1'b0);
    serviceBurst("f2 b3", 32'h7080_1800, 1'b0, 1'b0);
    tick();
    checkOutput("f2 done count", 32'(done_pulses), 32'd2);
    checkOutput("f2 rd_sel", 32'(rd_buf_sel_o), 32'd1);
    checkOutput("f2 wr_sel", 32'(wr_buf_sel_o), 32'd0);
    repeat (10) tick();
    checkOutput("f2 single seq req", 32'(wr_req_o), 32'd0);
    checkOutput("f2 single seq busy", 32'(busy_o), 32'd0);
    checkOutput("f2 no err", 32'(err_pulses), 32'd0);

    $display("[TB] frame 3 restarted during burst 3");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    waitReq(n);
    frame_start_sync_i = 1'b0;
    serviceBurst("f3 b0", 32'h7000_0000, 1'b0, 1'b0);
    serviceBurst("f3 b1", 32'h7000_0800, 1'b0, 1'b0);
    serviceBurst("f3 b2", 32'h7000_1000, 1'b1, 1'b1);
    checkOutput("restart addr", wr_addr_o, 32'h7000_0000);
    checkOutput("restart busy", 32'(busy_o), 32'd1);
    checkOutput("restart wr_sel", 32'(wr_buf_sel_o), 32'd0);
    checkOutput("restart err count", 32'(err_pulses), 32'd1);
    checkOutput("restart no done", 32'(done_pulses), 32'd2);

    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        wr_done_i = 1'b1;
        wr_ack_i  = 1'b1;
      end else begin
        wr_done_i = 1'b0;
        wr_ack_i  = 1'b0;
      end
      tick();
      if (wr_req_o !== 1'b0) req_seen++;
    end
    wr_done_i = 1'b0;
    wr_ack_i  = 1'b0;
    checkOutput("stall no req", 32'(req_seen), 32'd0);
    checkOutput("stall stray done addr", wr_addr_o, 32'h7000_0000);
    burst_rdy_i = 1'b1;
    tick();
    checkOutput("rdy to req 1 cycle", 32'(wr_req_o), 32'd1);
    serviceBurst("f3r b0", 32'h7000_0000, 1'b0, 1'b0);
    serviceBurst("f3r b1", 32'h7000_0800, 1'b0, 1'b0);
    serviceBurst("f3r b2", 32'h7000_1000, 1'b0, 1'b0);
    serviceBurst("f3r b3", 32'h7000_1800, 1'b0, 1'b0);
    tick();
    checkOutput("f3 done count", 32'(done_pulses), 32'd3);
    checkOutput("f3 rd_sel", 32'(rd_buf_sel_o), 32'd0);
    checkOutput("f3 wr_sel", 32'(wr_buf_sel_o), 32'd1);

    $display("[TB] asynchronous reset while requesting");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    waitReq(n);
    checkOutput("pre-reset req", 32'(wr_req_o), 32'd1);
    checkOutput("pre-reset addr", wr_addr_o, 32'h7080_0000);
    frame_start_sync_i = 1'b0;
    rstn_i = 1'b0;
    #1;
    checkOutput("async reset req", 32'(wr_req_o), 32'd0);
    checkOutput("async reset addr", wr_addr_o, 32'h7000_0000);
    checkOutput("async reset busy", 32'(busy_o), 32'd0);
    checkOutput("async reset wr_sel", 32'(wr_buf_sel_o), 32'd0);
    tick();
    rstn_i = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
